// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. The stage owns
//   the PC and issues req/ack fetches to instruction memory. It presents each
//   fetched word, its PC and a valid bit to decode. Decode stalls and EX-stage
//   branch redirects are handled here, including a fetch that is still in
//   flight when the redirect arrives.
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   stall_i         decode stall: IF/ID keeps its contents
//   flush_i         taken branch: redirect to branch_target_i and kill IF/ID
//   branch_target_i redirect address (bits [1:0] are forced to zero)
//   imem_req_o      fetch request, held until imem_ack_i
//   imem_addr_o     word-aligned fetch address
//   imem_ack_i      response valid; imem_rdata_i is sampled in this cycle
//   imem_rdata_i    instruction word
//   valid_d_o       IF/ID holds a live instruction
//   instr_d_o       IF/ID instruction (NOP_INSTR when invalid)
//   pc_d_o          PC of instr_d_o
//   op_d_o          instr_d_o[6:0]
//   funct_d_o       instr_d_o[14:12]
module fetch_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] branch_target_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            valid_d_o,
   output logic [31:0]     instr_d_o,
   output logic [XLEN-1:0] pc_d_o,
   output logic [6:0]      op_d_o,
   output logic [2:0]      funct_d_o
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

   state_t          state_reg;
   logic [XLEN-1:0] pc_reg;          // next address in program order
   logic [XLEN-1:0] addr_reg;        // address currently on the bus
   logic            req_reg;
   logic            valid_reg;
   logic [31:0]     instr_reg;
   logic [XLEN-1:0] pcd_reg;
   logic [31:0]     buf_instr_reg;   // word captured while decode was stalled
   logic [XLEN-1:0] buf_pc_reg;

   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] target_aligned;

   // Wraps modulo 2^XLEN by construction.
   assign pc_inc         = pc_reg + XLEN'(4);
   assign target_aligned = branch_target_i & ~XLEN'(3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_PC;
         addr_reg      <= RESET_PC;
         req_reg       <= 1'b0;
         valid_reg     <= 1'b0;
         instr_reg     <= NOP_INSTR;
         pcd_reg       <= '0;
         buf_instr_reg <= NOP_INSTR;
         buf_pc_reg    <= '0;
      end else if (flush_i) begin
         // A redirect beats both stall and ack: IF/ID is always killed.
         pc_reg    <= target_aligned;
         valid_reg <= 1'b0;
         instr_reg <= NOP_INSTR;
         pcd_reg   <= '0;
         if ((state_reg == FETCH || state_reg == DRAIN) && !imem_ack_i) begin
            // The bus request cannot be withdrawn; keep the old address up
            // until memory answers and throw that answer away.
            state_reg <= DRAIN;
         end else begin
            state_reg <= FETCH;
            req_reg   <= 1'b1;
            addr_reg  <= target_aligned;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg <= FETCH;
               req_reg   <= 1'b1;
               addr_reg  <= pc_reg;
               if (!stall_i) begin
                  valid_reg <= 1'b0;
                  instr_reg <= NOP_INSTR;
                  pcd_reg   <= '0;
               end
            end
            FETCH: begin
               if (imem_ack_i) begin
                  pc_reg <= pc_inc;
                  if (stall_i) begin
                     buf_instr_reg <= imem_rdata_i;
                     buf_pc_reg    <= pc_reg;
                     state_reg     <= HOLD;
                     req_reg       <= 1'b0;
                  end else begin
                     valid_reg <= 1'b1;
                     instr_reg <= imem_rdata_i;
                     pcd_reg   <= pc_reg;
                     addr_reg  <= pc_inc;
                  end
               end else if (!stall_i) begin
                  valid_reg <= 1'b0;
                  instr_reg <= NOP_INSTR;
                  pcd_reg   <= '0;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  valid_reg <= 1'b1;
                  instr_reg <= buf_instr_reg;
                  pcd_reg   <= buf_pc_reg;
                  state_reg <= FETCH;
                  req_reg   <= 1'b1;
                  addr_reg  <= pc_reg;
               end
            end
            DRAIN: begin
               if (imem_ack_i) begin
                  state_reg <= FETCH;
                  addr_reg  <= pc_reg;
               end
               if (!stall_i) begin
                  valid_reg <= 1'b0;
                  instr_reg <= NOP_INSTR;
                  pcd_reg   <= '0;
               end
            end
            default: begin
               state_reg <= IDLE;
               req_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_o  = req_reg;
   assign imem_addr_o = addr_reg;
   assign valid_d_o   = valid_reg;
   assign instr_d_o   = instr_reg;
   assign pc_d_o      = pcd_reg;
   assign op_d_o      = instr_reg[6:0];
   assign funct_d_o   = instr_reg[14:12];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Bench for fetch_stage: a variable-latency instruction memory, a
//   program-order reference model and directed plus random stimulus.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] target = '0;
   logic        req, ack;
   logic [31:0] addr, rdata;
   logic        valid_d;
   logic [31:0] instr_d, pc_d;
   logic [6:0]  op_d;
   logic [2:0]  funct_d;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_stage u_dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
      .branch_target_i(target), .imem_req_o(req), .imem_addr_o(addr),
      .imem_ack_i(ack), .imem_rdata_i(rdata), .valid_d_o(valid_d),
      .instr_d_o(instr_d), .pc_d_o(pc_d), .op_d_o(op_d), .funct_d_o(funct_d)
   );

   // Second instance for the wrap-around reset address.
   logic        req2, ack2 = 1'b0, valid2;
   logic [31:0] addr2, instr2, pc2;
   logic [6:0]  op2;
   logic [2:0]  funct2;
   logic [31:0] seen2[$];

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .flush_i(1'b0),
      .branch_target_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
      .imem_ack_i(ack2), .imem_rdata_i(addr2 | 32'h13), .valid_d_o(valid2),
      .instr_d_o(instr2), .pc_d_o(pc2), .op_d_o(op2), .funct_d_o(funct2)
   );

   always @(posedge clk) begin
      ack2 <= req2 && !ack2;
      if (!rst_n) seen2.delete();
      else if (req2 && ack2) seen2.push_back(addr2);
   end

   // Instruction memory: answers each request after 0..3 extra cycles with
   // addr|0x13 and only while the request is up. inj_ack forces a stray ack.
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   int          wait_cnt = 0;
   int          fixed_lat = 0;
   logic        inj_ack = 1'b0;

   assign ack   = mem_ack | inj_ack;
   assign rdata = inj_ack ? 32'hDEAD_0013 : mem_rdata;

   always @(posedge clk) begin
      if (mem_ack) begin
         mem_ack <= 1'b0;
      end else if (req) begin
         if (wait_cnt <= 0) begin
            mem_ack   <= 1'b1;
            mem_rdata <= addr | 32'h13;
            wait_cnt  <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
         end else begin
            wait_cnt <= wait_cnt - 1;
         end
      end
   end

   // Reference model: program-order PC, a one-word stall queue, a flag for
   // an abandoned request still owed an answer, and the expected IF/ID word.
   bit          started = 0;
   bit          m_idle, m_drain, m_rst_pc;
   logic [31:0] m_pc, m_drain_addr;
   logic [31:0] hq_instr[$];
   logic [31:0] hq_pc[$];
   logic        exp_valid;
   logic [31:0] exp_instr, exp_pcd;

   task automatic m_bubble();
      exp_valid = 1'b0;
      exp_instr = NOP;
      m_rst_pc  = 0;
   endtask

   task automatic m_load(input logic [31:0] w, input logic [31:0] p);
      exp_valid = 1'b1;
      exp_instr = w;
      exp_pcd   = p;
      m_rst_pc  = 0;
   endtask

   always @(posedge clk) begin
      bit req_now;
      started = 1;
      req_now = !m_idle && hq_pc.size() == 0;
      if (!rst_n) begin
         exp_valid = 1'b0; exp_instr = NOP; exp_pcd = '0; m_rst_pc = 1;
         m_pc = RST_PC; m_idle = 1; m_drain = 0;
         hq_instr.delete(); hq_pc.delete();
      end else if (flush) begin
         m_bubble();
         if (!m_drain) m_drain_addr = m_pc;
         m_drain = req_now && !ack;
         m_pc    = target & ~32'h3;
         m_idle  = 0;
         hq_instr.delete(); hq_pc.delete();
      end else if (m_idle) begin
         m_idle = 0;
         if (!stall) m_bubble();
      end else if (m_drain) begin
         if (ack) m_drain = 0;
         if (!stall) m_bubble();
      end else if (hq_pc.size() != 0) begin
         if (!stall) m_load(hq_instr.pop_front(), hq_pc.pop_front());
      end else if (ack && req_now) begin
         if (stall) begin
            hq_instr.push_back(rdata);
            hq_pc.push_back(m_pc);
         end else begin
            m_load(rdata, m_pc);
         end
         m_pc = m_pc + 32'd4;
      end else if (!stall) begin
         m_bubble();
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end else begin
         $display("[TB] ok %s: %08h", tag, obs);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         logic       exp_req;
         logic [6:0] e_op;
         logic [2:0] e_fn;
         exp_req = !m_idle && hq_pc.size() == 0;
         e_op    = exp_instr[6:0];
         e_fn    = exp_instr[14:12];
         check("req", req, exp_req);
         if (exp_req) check("addr", addr, m_drain ? m_drain_addr : m_pc);
         check("valid", valid_d, exp_valid);
         check("instr", instr_d, exp_instr);
         check("op", op_d, e_op);
         check("funct", funct_d, e_fn);
         if (exp_valid || m_rst_pc) check("pc_d", pc_d, m_rst_pc ? 32'h0 : exp_pcd);
      end
   end

   // Waits (bounded) for a negedge with req high and ack in the wanted state.
   task automatic wait_req(input logic want_ack, input string tag);
      int i;
      for (i = 0; i < 40; i++) begin
         @(negedge clk);
         if (req && ack == want_ack) break;
      end
      if (i == 40) begin
         n_tests++; n_fail++;
         $display("[TB] FAIL %s: timeout waiting for req/ack=%0d", tag, want_ack);
      end
   endtask

   initial begin
      logic [31:0] saved;
      int i;
      repeat (3) @(negedge clk);
      check("rst_req", req, 1'b0);
      check("rst_valid", valid_d, 1'b0);
      check("rst_instr", instr_d, NOP);
      check("rst_pc_d", pc_d, 32'h0);
      rst_n = 1'b1;

      // Plain streaming, one-cycle memory.
      repeat (14) @(negedge clk);

      // Stall across a landing ack.
      stall = 1'b1;
      repeat (5) @(negedge clk);
      stall = 1'b0;
      repeat (6) @(negedge clk);

      // Redirect to 0x102 while a slow fetch is outstanding.
      fixed_lat = 2;
      wait_req(1'b1, "t3_sync");
      wait_req(1'b0, "t3_outstanding");
      saved  = addr;
      flush  = 1'b1;
      target = 32'h0000_0102;
      @(negedge clk);
      flush = 1'b0;
      check("t3_drain_req", req, 1'b1);
      check("t3_drain_addr", addr, saved);
      for (i = 0; i < 20; i++) begin
         if (ack) break;
         @(negedge clk);
      end
      @(negedge clk);
      check("t3_new_addr", addr, 32'h0000_0100);
      check("t3_valid", valid_d, 1'b0);
      repeat (8) @(negedge clk);

      // Flush and stall together with an ack.
      fixed_lat = 0;
      wait_req(1'b1, "t4_ack");
      flush  = 1'b1;
      stall  = 1'b1;
      target = 32'h0000_0200;
      @(negedge clk);
      flush = 1'b0;
      stall = 1'b0;
      check("t4_instr", instr_d, 32'h13);
      check("t4_op", op_d, 7'b0010011);
      check("t4_funct", funct_d, 3'b000);
      check("t4_addr", addr, 32'h0000_0200);

      // Random traffic with occasional stalls, redirects and resets.
      fixed_lat = -1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         stall  = ($urandom_range(0, 3) == 0);
         flush  = ($urandom_range(0, 19) == 0);
         target = $urandom;
         rst_n  = ($urandom_range(0, 299) != 0);
      end
      @(negedge clk);
      stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Reset while draining, with a late ack right after.
      fixed_lat = 3;
      wait_req(1'b1, "t6_sync");
      wait_req(1'b0, "t6_outstanding");
      flush  = 1'b1;
      target = 32'h0000_0040;
      @(negedge clk);
      flush = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_req", req, 1'b0);
      check("t6_valid", valid_d, 1'b0);
      rst_n   = 1'b1;
      inj_ack = 1'b1;
      @(negedge clk);
      inj_ack = 1'b0;
      check("t6_late_valid", valid_d, 1'b0);
      check("t6_addr", addr, RST_PC);
      repeat (12) @(negedge clk);

      // Wrap-around reset address.
      if (seen2.size() >= 2) begin
         check("t5_first", seen2[0], 32'hFFFF_FFFC);
         check("t5_second", seen2[1], 32'h0000_0000);
      end else begin
         check("t5_count", seen2.size(), 2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
